// File: rtl/gmm_rate_div_sched_if.sv
// Handshake bundle between the rate sequencer and a shared floating-point
// divider.
//   master (sequencer) drives the operands, the operand strobes, the quotient
//   ack and the divider flush. It receives the operand acks and the quotient
//   with its strobe.
//   slave (divider) is the mirror image of master.
interface gmm_rate_div_sched_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] div_a;      // dividend
  logic [DATA_W-1:0] div_b;      // divisor
  logic              div_a_stb;
  logic              div_b_stb;
  logic              div_a_ack;
  logic              div_b_ack;
  logic [DATA_W-1:0] div_z;      // quotient
  logic              div_z_stb;
  logic              div_z_ack;
  logic              div_rst;    // one-cycle active-high divider flush

  modport master (
    output div_a, div_b, div_a_stb, div_b_stb, div_z_ack, div_rst,
    input  div_a_ack, div_b_ack, div_z, div_z_stb
  );

  modport slave (
    input  div_a, div_b, div_a_stb, div_b_stb, div_z_ack, div_rst,
    output div_a_ack, div_b_ack, div_z, div_z_stb
  );
endinterface

// File: rtl/gmm_rate_div_sched.sv
// Time-shares one floating-point divider across the NUM_K Gaussian components
// of a pixel. It computes rate_k = w_k / sigma_k for each component in turn and
// presents all rates together with a single rates_valid_o pulse. A zero sigma
// (either sign) bypasses the divider and yields +inf. A watchdog aborts a
// division that takes TIMEOUT cycles, returns 0 for that component, and
// flushes the divider.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   start_i                 latch w*/sigma* and begin; ignored while busy_o
//   w0_i..w2_i, sigma*_i    component weights / sigmas
//   div                     divider handshake bundle (master side)
//   rate0_o..rate2_o        registered rates, held until the next completion
//   rates_valid_o           one-cycle pulse, rates valid
//   busy_o                  high from the accepted start through the done cycle
//   err_timeout_o           sticky timeout flag, cleared by the next start
// The port list is fixed at three components, so NUM_K must be 3.
module gmm_rate_div_sched #(
  parameter int DATA_W  = 32,
  parameter int NUM_K   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DATA_W-1:0]    w0_i,
  input  logic [DATA_W-1:0]    w1_i,
  input  logic [DATA_W-1:0]    w2_i,
  input  logic [DATA_W-1:0]    sigma0_i,
  input  logic [DATA_W-1:0]    sigma1_i,
  input  logic [DATA_W-1:0]    sigma2_i,
  gmm_rate_div_sched_if.master div,
  output logic [DATA_W-1:0]    rate0_o,
  output logic [DATA_W-1:0]    rate1_o,
  output logic [DATA_W-1:0]    rate2_o,
  output logic                 rates_valid_o,
  output logic                 busy_o,
  output logic                 err_timeout_o
);
  localparam int KW = (NUM_K > 1) ? $clog2(NUM_K) : 1;
  localparam logic [DATA_W-1:0] POS_INF = DATA_W'(32'h7F80_0000);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_Z, NEXT, DONE} state_e;

  state_e                         state_q, state_d;
  logic [KW-1:0]                  k_q;
  logic [7:0]                     timer_q;
  logic                           a_done_q, b_done_q, div_rst_q;
  logic [NUM_K-1:0][DATA_W-1:0]   w_q, s_q, rate_q, rate_out_q;

  logic sigma_zero, tmo, last_k, a_ok, b_ok;

  // Sign bit ignored so that -0 is also bypassed.
  assign sigma_zero = (s_q[k_q][DATA_W-2:0] == '0);
  // The timer starts at 0 on the first ISSUE cycle, so this fires on the
  // TIMEOUT-th cycle spent on one division.
  assign tmo        = (timer_q == 8'(TIMEOUT-1));
  assign last_k     = (k_q == KW'(NUM_K-1));
  // An operand counts as delivered once its ack has been sampled while its
  // strobe was up, whether in an earlier cycle or in this one.
  assign a_ok       = a_done_q | (div.div_a_stb & div.div_a_ack);
  assign b_ok       = b_done_q | (div.div_b_stb & div.div_b_ack);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_i) state_d = ISSUE;
      ISSUE:  if (sigma_zero || tmo) state_d = NEXT;
              else if (a_ok && b_ok) state_d = WAIT_Z;
      WAIT_Z: if (tmo || div.div_z_stb) state_d = NEXT;
      NEXT:   state_d = last_k ? DONE : ISSUE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    div.div_a_stb = 1'b0;
    div.div_b_stb = 1'b0;
    div.div_z_ack = 1'b0;
    rates_valid_o = 1'b0;
    busy_o        = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        div.div_a_stb = !sigma_zero && !a_done_q;
        div.div_b_stb = !sigma_zero && !b_done_q;
      end
      WAIT_Z: div.div_z_ack = 1'b1;
      DONE:   rates_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign div.div_a   = w_q[k_q];
  assign div.div_b   = s_q[k_q];
  assign div.div_rst = div_rst_q;
  assign rate0_o     = rate_out_q[0];
  assign rate1_o     = rate_out_q[1];
  assign rate2_o     = rate_out_q[2];

  // Datapath, operand bookkeeping and watchdog
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      k_q           <= '0;
      timer_q       <= '0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
      div_rst_q     <= 1'b0;
      err_timeout_o <= 1'b0;
      w_q           <= '0;
      s_q           <= '0;
      rate_q        <= '0;
      rate_out_q    <= '0;
    end else begin
      div_rst_q <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (start_i) begin
            w_q           <= {w2_i, w1_i, w0_i};
            s_q           <= {sigma2_i, sigma1_i, sigma0_i};
            k_q           <= '0;
            a_done_q      <= 1'b0;
            b_done_q      <= 1'b0;
            err_timeout_o <= 1'b0;
          end
        end
        ISSUE: begin
          timer_q <= timer_q + 8'd1;
          if (sigma_zero) begin
            rate_q[k_q] <= POS_INF;
          end else begin
            if (a_ok) a_done_q <= 1'b1;
            if (b_ok) b_done_q <= 1'b1;
          end
        end
        WAIT_Z: begin
          timer_q <= timer_q + 8'd1;
          // The abort below takes priority over a quotient that arrives in
          // the timeout cycle.
          if (div.div_z_stb) rate_q[k_q] <= div.div_z;
        end
        NEXT: begin
          timer_q  <= '0;
          a_done_q <= 1'b0;
          b_done_q <= 1'b0;
          if (last_k) rate_out_q <= rate_q;
          else        k_q        <= k_q + KW'(1);
        end
        default: timer_q <= '0;
      endcase

      // Watchdog abort, last so that it overrides the updates above.
      if (tmo && !sigma_zero && (state_q == ISSUE || state_q == WAIT_Z)) begin
        rate_q[k_q]   <= '0;
        err_timeout_o <= 1'b1;
        div_rst_q     <= 1'b1;
        a_done_q      <= 1'b0;
        b_done_q      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gmm_rate_div_sched.sv
module tb_gmm_rate_div_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] w0 = '0, w1 = '0, w2 = '0, s0 = '0, s1 = '0, s2 = '0;
  logic [31:0] r0, r1, r2;
  logic        rv, busy, err;

  gmm_rate_div_sched_if #(.DATA_W(32)) dif ();

  gmm_rate_div_sched #(.DATA_W(32), .NUM_K(3), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .w0_i(w0), .w1_i(w1), .w2_i(w2),
    .sigma0_i(s0), .sigma1_i(s1), .sigma2_i(s2),
    .div(dif),
    .rate0_o(r0), .rate1_o(r1), .rate2_o(r2),
    .rates_valid_o(rv), .busy_o(busy), .err_timeout_o(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference quotients for the operand pairs used below.
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h3F000000; // 1/2
      {32'h40000000, 32'h40800000}: return 32'h3F000000; // 2/4
      {32'h40400000, 32'h3F800000}: return 32'h40400000; // 3/1
      {32'h40C00000, 32'h40000000}: return 32'h40400000; // 6/2
      {32'h3F800000, 32'h40800000}: return 32'h3E800000; // 1/4
      {32'h40A00000, 32'h40A00000}: return 32'h3F800000; // 5/5
      default:                      return 32'hFFC00000;
    endcase
  endfunction

  // ---------------- divider model (responds on the falling edge) ----------
  int a_dly = 0, b_dly = 0, z_dly = 2, hang_txn = -1;
  int a_wait = 0, b_wait = 0, z_wait = 0;
  int run_txn = 0, cur_txn = 0, txn_cnt = 0, rv_cnt = 0, drst_cnt = 0;
  int negcnt = 0, ack_a_at = 0, ack_b_at = 0;
  bit got_a = 0, got_b = 0, z_take = 0;
  logic [31:0] op_a = '0, op_b = '0;
  bit stb_a_log [1024];
  bit stb_b_log [1024];

  always @(negedge clk) begin
    negcnt++;
    stb_a_log[negcnt % 1024] = dif.div_a_stb;
    stb_b_log[negcnt % 1024] = dif.div_b_stb;
    if (rv) rv_cnt++;
    if (dif.div_rst) drst_cnt++;
    if (!rst_n || dif.div_rst) begin
      dif.div_a_ack = 1'b0; dif.div_b_ack = 1'b0;
      dif.div_z_stb = 1'b0; dif.div_z = '0;
      got_a = 0; got_b = 0; z_take = 0;
      a_wait = 0; b_wait = 0; z_wait = 0;
    end else begin
      if (dif.div_z_stb && z_take) begin
        dif.div_z_stb = 1'b0; got_a = 0; got_b = 0; z_wait = 0;
      end
      if (dif.div_a_ack) dif.div_a_ack = 1'b0;
      else if (dif.div_a_stb && !got_a) begin
        if (a_wait == a_dly) begin
          dif.div_a_ack = 1'b1; got_a = 1; a_wait = 0; op_a = dif.div_a;
          ack_a_at = negcnt; cur_txn = run_txn; run_txn++; txn_cnt++;
        end else a_wait++;
      end
      if (dif.div_b_ack) dif.div_b_ack = 1'b0;
      else if (dif.div_b_stb && !got_b) begin
        if (b_wait == b_dly) begin
          dif.div_b_ack = 1'b1; got_b = 1; b_wait = 0; op_b = dif.div_b; ack_b_at = negcnt;
        end else b_wait++;
      end
      if (got_a && got_b && !dif.div_a_ack && !dif.div_b_ack && !dif.div_z_stb
          && cur_txn != hang_txn) begin
        if (z_wait == z_dly) begin
          dif.div_z_stb = 1'b1; dif.div_z = fdiv(op_a, op_b);
        end else z_wait++;
      end
      z_take = dif.div_z_stb && dif.div_z_ack;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] w0, w1, w2, s0, s1, s2, e0, e1, e2;
    int          txn;   // expected divider transactions
    int          hang;  // transaction index the divider never answers, -1 none
    logic        err;   // expected err_timeout_o
    int          lat;   // edges from start edge to rates_valid, -1 = don't care
  } vec_t;

  vec_t vt [6];

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, tx0, rv0, dr0;
    w0 = v.w0; w1 = v.w1; w2 = v.w2; s0 = v.s0; s1 = v.s1; s2 = v.s2;
    hang_txn = v.hang; run_txn = 0;
    tx0 = txn_cnt; rv0 = rv_cnt; dr0 = drst_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("%s.busy_after_start", tag), 32'(busy), 32'd1);
    chk($sformatf("%s.err_clear_on_start", tag), 32'(err), 32'd0);
    cyc = 0;
    while (!rv && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("%s.rates_valid_seen", tag), 32'(rv), 32'd1);
    if (rv) begin
      chk($sformatf("%s.rate0", tag), r0, v.e0);
      chk($sformatf("%s.rate1", tag), r1, v.e1);
      chk($sformatf("%s.rate2", tag), r2, v.e2);
      chk($sformatf("%s.err", tag), 32'(err), 32'(v.err));
      chk($sformatf("%s.busy_in_done", tag), 32'(busy), 32'd1);
      if (v.lat >= 0) chk($sformatf("%s.latency", tag), 32'(cyc), 32'(v.lat));
      if (v.hang >= 0) chk($sformatf("%s.waited_watchdog", tag), 32'(cyc >= 255), 32'd1);
    end
    @(posedge clk); #1;
    chk($sformatf("%s.busy_idle", tag), 32'(busy), 32'd0);
    chk($sformatf("%s.rv_one_cycle", tag), 32'(rv), 32'd0);
    chk($sformatf("%s.rates_hold", tag), r0, v.e0);
    chk($sformatf("%s.txn_count", tag), 32'(txn_cnt - tx0), 32'(v.txn));
    chk($sformatf("%s.rv_pulses", tag), 32'(rv_cnt - rv0), 32'd1);
    chk($sformatf("%s.div_rst_cycles", tag), 32'(drst_cnt - dr0), 32'(v.err ? 1 : 0));
    hang_txn = -1;
  endtask

  initial begin
    int n_a, n_b, cyc, rv0;
    // w, sigma, expected rates, txn, hang, err, latency
    vt[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h40800000, 32'h3F800000,
              32'h3F000000, 32'h3F000000, 32'h40400000, 3, -1, 1'b0, -1};
    vt[1] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h3F800000,
              32'h3F000000, 32'h7F800000, 32'h40400000, 2, -1, 1'b0, -1};
    vt[2] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h80000000, 32'h3F800000,
              32'h3F000000, 32'h7F800000, 32'h40400000, 2, -1, 1'b0, -1};
    // All sigma zero: start cycle through rates_valid cycle is 1+2K+1 = 8
    // cycles, i.e. rates_valid is seen 6 edges after the start edge.
    vt[3] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h00000000, 32'h80000000, 32'h00000000,
              32'h7F800000, 32'h7F800000, 32'h7F800000, 0, -1, 1'b0, 6};
    vt[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h40800000, 32'h3F800000,
              32'h00000000, 32'h3F000000, 32'h40400000, 3, 0, 1'b1, -1};
    vt[5] = '{32'h40C00000, 32'h3F800000, 32'h40A00000, 32'h40000000, 32'h40800000, 32'h40A00000,
              32'h40400000, 32'h3E800000, 32'h3F800000, 3, -1, 1'b0, -1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.rv", 32'(rv), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.rate0", r0, 32'd0);
    chk("reset.stb", 32'({dif.div_a_stb, dif.div_b_stb, dif.div_z_ack, dif.div_rst}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

    // Dividend acked at once, divisor four cycles later.
    a_dly = 0; b_dly = 4;
    run_vec(vt[0], "skew_ack");
    n_a = ack_a_at; n_b = ack_b_at;
    chk("skew.b_ack_gap", 32'(n_b - n_a), 32'd4);
    chk("skew.a_stb_at_n", 32'(stb_a_log[n_a % 1024]), 32'd1);
    chk("skew.a_stb_drop", 32'(stb_a_log[(n_a + 1) % 1024]), 32'd0);
    chk("skew.b_stb_hold", 32'(stb_b_log[(n_a + 1) % 1024] & stb_b_log[n_b % 1024]), 32'd1);
    chk("skew.b_stb_drop", 32'(stb_b_log[(n_b + 1) % 1024]), 32'd0);
    a_dly = 0; b_dly = 0;

    // start while busy and in the done cycle must be ignored.
    w0 = vt[0].w0; w1 = vt[0].w1; w2 = vt[0].w2; s0 = vt[0].s0; s1 = vt[0].s1; s2 = vt[0].s2;
    rv0 = rv_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    w0 = vt[5].w0; w1 = vt[5].w1; w2 = vt[5].w2; s0 = vt[5].s0; s1 = vt[5].s1; s2 = vt[5].s2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!rv && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("busy_start.rv_seen", 32'(rv), 32'd1);
    chk("busy_start.rate0", r0, vt[0].e0);
    chk("busy_start.rate2", r2, vt[0].e2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start.busy", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("done_start.still_idle", 32'(busy), 32'd0);
    chk("done_start.rv_pulses", 32'(rv_cnt - rv0), 32'd1);

    // Reset in the middle of a quotient wait.
    z_dly = 20;
    w0 = vt[5].w0; w1 = vt[5].w1; w2 = vt[5].w2; s0 = vt[5].s0; s1 = vt[5].s1; s2 = vt[5].s2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!dif.div_z_ack && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrst.in_wait_z", 32'(dif.div_z_ack), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.rates", r0 | r1 | r2, 32'd0);
    chk("midrst.flags", 32'({rv, err, dif.div_a_stb, dif.div_b_stb, dif.div_z_ack, dif.div_rst}), 32'd0);
    chk("midrst.div_a", dif.div_a, 32'd0);
    rst_n = 1'b1;
    z_dly = 2;
    @(posedge clk); #1;
    run_vec(vt[5], "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
